wb_ram_bsel: RTL

//  Parametrised Wishbone-style data/instruction RAM, successor of the fixed 32-bit RAM.

---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_ram_bsel.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone slave definitions: FSM state type and address/lane helpers
// reused by every memory-style Wb slave.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } wb_slave_state_t;

    // Addresses are widened to 64 bits so one helper serves every bus width.
    function automatic logic is_aligned(input logic [63:0] addr, input int unsigned wb);
        return (addr % 64'(wb)) == 64'd0;
    endfunction

    function automatic logic in_range(input logic [63:0] addr, input int unsigned wb,
                                      input int unsigned cap);
        return addr <= (64'(cap) - 64'(wb));
    endfunction

    function automatic logic [7:0] lane_mask(input logic en);
        return {8{en}};
    endfunction

endpackage

// File: rtl/wb_ram_bsel.sv
// Wishbone byte-addressed RAM slave with per-lane write enables, programmable
// wait states and an error response for misaligned or out-of-range accesses.
module wb_ram_bsel
    import wb_pkg::*;
#(
    parameter int          ADDR_SIZE   = 32,
    parameter int          WORD_SIZE   = 32,
    parameter int          CAPACITY_B  = 1024,
    parameter int          WAIT_STATES = 0,
    parameter logic [7:0]  INIT_BYTE   = 8'hff
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [ADDR_SIZE-1:0]   Wb_addr,
    input  logic                   Wb_cs,
    input  logic                   Wb_we,
    input  logic [WORD_SIZE/8-1:0] Wb_sel,
    input  logic [WORD_SIZE-1:0]   Wb_wdata,
    output logic [WORD_SIZE-1:0]   Wb_rdata,
    output logic                   Wb_ack,
    output logic                   Wb_err
);

    localparam int          WB      = WORD_SIZE / 8;
    localparam int          IDX_W   = (CAPACITY_B > 1) ? $clog2(CAPACITY_B) : 1;
    localparam int          WS_M1   = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [3:0]  WS_LOAD = WS_M1[3:0];

    wb_slave_state_t        state_q;
    logic [3:0]             cnt_q;
    logic [IDX_W-1:0]       base_q;
    logic                   we_q;
    logic [WB-1:0]          sel_q;
    logic [WORD_SIZE-1:0]   wdata_q;
    logic                   bad_q;
    logic                   ack_q;
    logic                   err_q;
    logic [WORD_SIZE-1:0]   rdata_q;
    logic [7:0]             mem_q [CAPACITY_B];

    logic                   req_bad_d;
    logic                   enter_resp_d;
    logic [IDX_W-1:0]       cur_base_d;
    logic                   cur_we_d;
    logic [WB-1:0]          cur_sel_d;
    logic [WORD_SIZE-1:0]   cur_wdata_d;
    logic                   cur_bad_d;
    logic [WORD_SIZE-1:0]   rd_word_d;

    assign req_bad_d = !(is_aligned(64'(Wb_addr), WB) && in_range(64'(Wb_addr), WB, CAPACITY_B));

    // With no wait states the access completes on the capture edge itself, so the
    // live bus stands in for the captured request while still in IDLE.
    always_comb begin
        if (state_q == IDLE) begin
            cur_base_d  = Wb_addr[IDX_W-1:0];
            cur_we_d    = Wb_we;
            cur_sel_d   = Wb_sel;
            cur_wdata_d = Wb_wdata;
            cur_bad_d   = req_bad_d;
        end else begin
            cur_base_d  = base_q;
            cur_we_d    = we_q;
            cur_sel_d   = sel_q;
            cur_wdata_d = wdata_q;
            cur_bad_d   = bad_q;
        end
    end

    always_comb begin
        enter_resp_d = 1'b0;
        if (state_q == IDLE && Wb_cs && WAIT_STATES == 0) begin
            enter_resp_d = 1'b1;
        end else if (state_q == WAIT && cnt_q == 4'd0) begin
            enter_resp_d = 1'b1;
        end
    end

    always_comb begin
        rd_word_d = '0;
        for (int i = 0; i < WB; i++) begin
            rd_word_d[8*i +: 8] = mem_q[cur_base_d + IDX_W'(i)];
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            if (enter_resp_d) begin
                state_q <= RESP;
                if (cur_bad_d) begin
                    err_q <= 1'b1;
                end else begin
                    ack_q <= 1'b1;
                    if (!cur_we_d) begin
                        rdata_q <= rd_word_d;
                    end
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (Wb_cs) begin
                            state_q <= WAIT;
                            cnt_q   <= WS_LOAD;
                        end
                    end
                    WAIT:    cnt_q   <= cnt_q - 4'd1;
                    RESP:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Request capture; held until the next IDLE so late bus changes are ignored.
    always_ff @(posedge Clk) begin
        if (state_q == IDLE && Wb_cs) begin
            base_q  <= Wb_addr[IDX_W-1:0];
            we_q    <= Wb_we;
            sel_q   <= Wb_sel;
            wdata_q <= Wb_wdata;
            bad_q   <= req_bad_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < CAPACITY_B; i++) begin
                mem_q[i] <= INIT_BYTE;
            end
        end else if (enter_resp_d && cur_we_d && !cur_bad_d) begin
            for (int i = 0; i < WB; i++) begin
                mem_q[cur_base_d + IDX_W'(i)] <=
                    (mem_q[cur_base_d + IDX_W'(i)] & ~lane_mask(cur_sel_d[i])) |
                    (cur_wdata_d[8*i +: 8] & lane_mask(cur_sel_d[i]));
            end
        end
    end

    assign Wb_ack   = ack_q;
    assign Wb_err   = err_q;
    assign Wb_rdata = rdata_q;

endmodule
